// File: rtl/fft_pkg.sv
// Shared FFT datapath types: sample width, lane count, complex sample and factor select.
// Latency: none (types and constants only).
// Backpressure: n/a.
package fft_pkg;

   localparam int FFT_DATA_W = 10;
   localparam int FFT_LANES  = 16;

   typedef logic signed [FFT_DATA_W-1:0] fft_data_t;

   typedef struct packed {
      fft_data_t re;
      fft_data_t im;
   } cplx_t;

   typedef enum logic {
      FAC_ONE   = 1'b0,
      FAC_NEG_J = 1'b1
   } fac_t;

   // Extremes of the signed sample range; -DATA_MIN is the only unrepresentable negation.
   localparam fft_data_t DATA_MAX = fft_data_t'({1'b0, {(FFT_DATA_W-1){1'b1}}});
   localparam fft_data_t DATA_MIN = fft_data_t'({1'b1, {(FFT_DATA_W-1){1'b0}}});

endpackage

// File: rtl/mod0_fac8_0_negj.sv
// Per-lane factor unit: multiplies one complex sample by 1 or -j.
// Latency: combinational.
// Backpressure: none; purely combinational.
//
// Ports:
//   x_i   complex input sample
//   sel_i factor select (FAC_ONE pass-through, FAC_NEG_J rotate by -j)
//   y_o   complex result, same width as input
//
// Build option FFT_FAC8_0_SAT_EN: when defined, negating the most negative value
// saturates to the most positive value; otherwise it wraps (two's complement).
module mod0_fac8_0_negj
   import fft_pkg::*;
(
   input  cplx_t x_i,
   input  fac_t  sel_i,
   output cplx_t y_o
);

   fft_data_t neg_re;

   always_comb begin
`ifdef FFT_FAC8_0_SAT_EN
      if (x_i.re == DATA_MIN) begin
         neg_re = DATA_MAX;
      end else begin
         neg_re = -x_i.re;
      end
`else
      neg_re = -x_i.re;
`endif
      y_o = x_i;
      // (re + j*im) * (-j) = im - j*re
      if (sel_i == FAC_NEG_J) begin
         y_o.re = x_i.im;
         y_o.im = neg_re;
      end
   end

endmodule

// File: rtl/mod0_fac8_0_twiddle.sv
// FFT module 0 fac8_0 twiddle stage: applies factor pattern [1,1,1,-j] over beat position.
// Latency: 1 cycle, valid_out follows valid_in; dout holds when no beat arrives.
// Backpressure: none; every valid_in beat is accepted and emitted next cycle.
//
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   clr           synchronous frame restart (position/beat counters to 0)
//   valid_in      input beat strobe
//   din_re/im     LANES signed samples per beat
//   valid_out     output beat strobe
//   dout_re/im    LANES signed samples after the factor
//   frame_done    pulse with the last output beat of a frame
//
// Build option FFT_FAC8_0_SAT_EN selects saturating negation (see mod0_fac8_0_negj).
// DATA_W and LANES must match fft_pkg, since lanes are carried as fft_pkg::cplx_t.
module mod0_fac8_0_twiddle
   import fft_pkg::*;
#(
   parameter int DATA_W      = FFT_DATA_W,
   parameter int LANES       = FFT_LANES,
   parameter int FRAME_BEATS = 32
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         clr,
   input  logic                         valid_in,
   input  logic [LANES-1:0][DATA_W-1:0] din_re,
   input  logic [LANES-1:0][DATA_W-1:0] din_im,
   output logic                         valid_out,
   output logic [LANES-1:0][DATA_W-1:0] dout_re,
   output logic [LANES-1:0][DATA_W-1:0] dout_im,
   output logic                         frame_done
);

   localparam int BEAT_W = $clog2(FRAME_BEATS);

   logic [1:0]        pos_q, pos_d, pos_eff;
   logic [BEAT_W-1:0] beat_q, beat_d, beat_eff;
   logic              last_beat;
   fac_t              fac;

   logic [LANES-1:0][DATA_W-1:0] res_re, res_im;

   logic                         valid_out_q;
   logic [LANES-1:0][DATA_W-1:0] dout_re_q, dout_im_q;
   logic                         frame_done_q;

   // clr restarts the frame in the same cycle, so a coincident beat is beat 0 (x1).
   always_comb begin
      pos_eff   = clr ? 2'd0 : pos_q;
      beat_eff  = clr ? '0 : beat_q;
      fac       = (pos_eff == 2'd3) ? FAC_NEG_J : FAC_ONE;
      pos_d     = pos_eff;
      beat_d    = beat_eff;
      last_beat = 1'b0;
      if (valid_in) begin
         pos_d     = pos_eff + 2'd1;
         beat_d    = beat_eff + BEAT_W'(1);
         last_beat = (beat_eff == BEAT_W'(FRAME_BEATS - 1));
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      cplx_t x, y;
      assign x.re      = din_re[g];
      assign x.im      = din_im[g];
      assign res_re[g] = y.re;
      assign res_im[g] = y.im;

      mod0_fac8_0_negj u_negj (
         .x_i   (x),
         .sel_i (fac),
         .y_o   (y)
      );
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pos_q        <= '0;
         beat_q       <= '0;
         valid_out_q  <= 1'b0;
         dout_re_q    <= '0;
         dout_im_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         pos_q        <= pos_d;
         beat_q       <= beat_d;
         valid_out_q  <= valid_in;
         frame_done_q <= last_beat;
         if (valid_in) begin
            dout_re_q <= res_re;
            dout_im_q <= res_im;
         end
      end
   end

   assign valid_out  = valid_out_q;
   assign dout_re    = dout_re_q;
   assign dout_im    = dout_im_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mod0_fac8_0_twiddle.sv
// Testbench for mod0_fac8_0_twiddle: directed vector table, hand sequences, randomized run.
// Latency: n/a.
// Backpressure: n/a.
module tb_mod0_fac8_0_twiddle;

   localparam int DW   = 10;
   localparam int LN   = 16;
   localparam int FB   = 32;
   localparam int MAXV = 511;

   logic                     clk = 1'b0;
   logic                     rstn;
   logic                     clr;
   logic                     valid_in;
   logic [LN-1:0][DW-1:0]    din_re, din_im;
   logic                     valid_out;
   logic [LN-1:0][DW-1:0]    dout_re, dout_im;
   logic                     frame_done;

   mod0_fac8_0_twiddle #(.DATA_W(DW), .LANES(LN), .FRAME_BEATS(FB)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .clr        (clr),
      .valid_in   (valid_in),
      .din_re     (din_re),
      .din_im     (din_im),
      .valid_out  (valid_out),
      .dout_re    (dout_re),
      .dout_im    (dout_im),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: beat index within frame plus last emitted values.
   int m_cnt;
   int m_re[LN];
   int m_im[LN];
   int m_vld;
   int m_fd;

   int stim_re[LN];
   int stim_im[LN];

   typedef struct {
      int v;   int c;   int re;  int im;
      int ev;  int ere; int eim; int efd;
   } vec_t;

   vec_t tbl[11];

   function automatic int neg_ref(input int v);
      int r;
      r = -v;
      if (r > MAXV) begin
`ifdef FFT_FAC8_0_SAT_EN
         r = MAXV;
`else
         r = r - (1 << DW);
`endif
      end
      return r;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int out_re(input int l);
      return int'($signed(dout_re[l]));
   endfunction

   function automatic int out_im(input int l);
      return int'($signed(dout_im[l]));
   endfunction

   task automatic model_reset();
      m_cnt = 0;
      m_vld = 0;
      m_fd  = 0;
      for (int l = 0; l < LN; l++) begin
         m_re[l] = 0;
         m_im[l] = 0;
      end
   endtask

   task automatic set_all(input int re, input int im);
      for (int l = 0; l < LN; l++) begin
         stim_re[l] = re;
         stim_im[l] = im;
      end
   endtask

   task automatic set_rand();
      for (int l = 0; l < LN; l++) begin
         stim_re[l] = int'($urandom_range(0, 1023)) - 512;
         stim_im[l] = int'($urandom_range(0, 1023)) - 512;
      end
   endtask

   // Drive one cycle, advance the model, then compare every output against it.
   task automatic step(input int v, input int c);
      valid_in = v[0];
      clr      = c[0];
      for (int l = 0; l < LN; l++) begin
         din_re[l] = stim_re[l][DW-1:0];
         din_im[l] = stim_im[l][DW-1:0];
      end
      if (c != 0) m_cnt = 0;
      m_vld = v;
      m_fd  = 0;
      if (v != 0) begin
         for (int l = 0; l < LN; l++) begin
            if (m_cnt % 4 == 3) begin
               m_re[l] = stim_im[l];
               m_im[l] = neg_ref(stim_re[l]);
            end else begin
               m_re[l] = stim_re[l];
               m_im[l] = stim_im[l];
            end
         end
         m_fd  = (m_cnt == FB - 1) ? 1 : 0;
         m_cnt = (m_cnt + 1) % FB;
      end
      @(posedge clk);
      #1;
      check("valid_out", int'(valid_out), m_vld);
      check("frame_done", int'(frame_done), m_fd);
      for (int l = 0; l < LN; l++) begin
         check("dout_re", out_re(l), m_re[l]);
         check("dout_im", out_im(l), m_im[l]);
      end
   endtask

   initial begin
      int fd_cnt;
      int fd_idx;

      rstn     = 1'b0;
      clr      = 1'b0;
      valid_in = 1'b0;
      din_re   = '0;
      din_im   = '0;
      set_all(0, 0);
      model_reset();

      // Test 1 and 2 vectors: four back-to-back beats, then gapped beats at 0,2,5,6.
      tbl[0]  = '{1, 0,    3,   5, 1,  3,  5, 0};
      tbl[1]  = '{1, 0,    3,   5, 1,  3,  5, 0};
      tbl[2]  = '{1, 0,    3,   5, 1,  3,  5, 0};
      tbl[3]  = '{1, 0,    3,   5, 1,  5, -3, 0};
      tbl[4]  = '{1, 0,    1,   2, 1,  1,  2, 0};
      tbl[5]  = '{0, 0,  100, 100, 0,  1,  2, 0};
      tbl[6]  = '{1, 0,    7,   8, 1,  7,  8, 0};
      tbl[7]  = '{0, 0, -100,  50, 0,  7,  8, 0};
      tbl[8]  = '{0, 0, -100,  50, 0,  7,  8, 0};
      tbl[9]  = '{1, 0,    9,  -4, 1,  9, -4, 0};
      tbl[10] = '{1, 0,   -6,  11, 1, 11,  6, 0};

      repeat (2) @(posedge clk);
      #1;
      check("reset_valid_out", int'(valid_out), 0);
      check("reset_frame_done", int'(frame_done), 0);
      check("reset_dout_re0", out_re(0), 0);
      check("reset_dout_im0", out_im(LN-1), 0);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         set_all(tbl[i].re, tbl[i].im);
         step(tbl[i].v, tbl[i].c);
         check("tbl_valid", int'(valid_out), tbl[i].ev);
         check("tbl_re0", out_re(0), tbl[i].ere);
         check("tbl_im0", out_im(0), tbl[i].eim);
         check("tbl_reN", out_re(LN-1), tbl[i].ere);
         check("tbl_fd", int'(frame_done), tbl[i].efd);
      end

      // Test 3: clr alone, then 33 continuous beats; one frame_done with beat 31.
      set_rand();
      step(0, 1);
      fd_cnt = 0;
      fd_idx = -1;
      for (int i = 0; i < 33; i++) begin
         set_rand();
         step(1, 0);
         if (frame_done) begin
            fd_cnt++;
            fd_idx = i;
         end
      end
      check("t3_fd_count", fd_cnt, 1);
      check("t3_fd_index", fd_idx, 31);

      // Test 4: most negative real part on a -j beat.
      set_rand();
      step(1, 1);
      step(1, 0);
      step(1, 0);
      set_rand();
      stim_re[0] = -512;
      stim_im[0] = 0;
      step(1, 0);
      check("t4_re0", out_re(0), 0);
`ifdef FFT_FAC8_0_SAT_EN
      check("t4_im0", out_im(0), 511);
`else
      check("t4_im0", out_im(0), -512);
`endif

      // Test 5: two beats, then clr with a beat; -j lands 3 beats later, frame_done 31 later.
      set_all(3, 5);
      step(1, 0);
      step(1, 0);
      step(1, 1);
      check("t5_clr_beat_re", out_re(0), 3);
      check("t5_clr_beat_im", out_im(0), 5);
      fd_idx = -1;
      for (int i = 1; i < 34; i++) begin
         step(1, 0);
         if (i == 3) begin
            check("t5_negj_re", out_re(0), 5);
            check("t5_negj_im", out_im(0), -3);
         end
         if (frame_done && fd_idx < 0) fd_idx = i;
      end
      check("t5_fd_index", fd_idx, 31);

      // Test 6: reset mid-frame after 13 beats.
      step(1, 1);
      for (int i = 1; i < 13; i++) step(1, 0);
      rstn     = 1'b0;
      valid_in = 1'b0;
      clr      = 1'b0;
      #1;
      check("t6_rst_valid", int'(valid_out), 0);
      check("t6_rst_re0", out_re(0), 0);
      check("t6_rst_im0", out_im(0), 0);
      check("t6_rst_fd", int'(frame_done), 0);
      model_reset();
      @(posedge clk);
      #2;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      fd_idx = -1;
      for (int i = 0; i < 34; i++) begin
         step(1, 0);
         if (i == 0) begin
            check("t6_first_re", out_re(0), 3);
            check("t6_first_im", out_im(0), 5);
         end
         if (frame_done && fd_idx < 0) fd_idx = i;
      end
      check("t6_fd_index", fd_idx, 31);

      // Randomized traffic with gaps and occasional clr.
      for (int i = 0; i < 400; i++) begin
         set_rand();
         step(($urandom_range(0, 9) < 7) ? 1 : 0, ($urandom_range(0, 19) == 0) ? 1 : 0);
      end
      step(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
